// File: rtl/student_deser16.sv
// Bit-serial to parallel deserializer with valid/ready on both sides.
// The out_any flag is built from the student gate library OR primitives.

module student_or (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = ~(~a & ~b);
endmodule

module student_or8way (
  input  logic [7:0] in,
  output logic       out
);
  logic or01, or23, or45, or67, or03, or47;

  student_or u_or01 (.a(in[0]), .b(in[1]), .out(or01));
  student_or u_or23 (.a(in[2]), .b(in[3]), .out(or23));
  student_or u_or45 (.a(in[4]), .b(in[5]), .out(or45));
  student_or u_or67 (.a(in[6]), .b(in[7]), .out(or67));
  student_or u_or03 (.a(or01),  .b(or23),  .out(or03));
  student_or u_or47 (.a(or45),  .b(or67),  .out(or47));
  student_or u_or07 (.a(or03),  .b(or47),  .out(out));
endmodule

module student_deser16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_any,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       bit_count
);
  // The top shift bit is never observed, so only WIDTH-1 bits are stored.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [3:0]       bit_count_q, bit_count_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_any_q, out_any_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] load_word;
  logic             any_hi, any_lo, load_any;
  logic             accept, complete, transfer;

  assign load_word = {shift_q, in_bit};

  student_or8way u_or_hi (.in(load_word[15:8]), .out(any_hi));
  student_or8way u_or_lo (.in(load_word[7:0]),  .out(any_lo));
  student_or     u_or_all (.a(any_hi), .b(any_lo), .out(load_any));

  // Only the word-completing bit can stall, and only while the output is full.
  assign in_ready = !(bit_count_q == 4'd15 && out_valid_q && !out_ready);

  always_comb begin
    shift_d     = shift_q;
    bit_count_d = bit_count_q;
    out_word_d  = out_word_q;
    out_any_d   = out_any_q;
    out_valid_d = out_valid_q;

    accept   = in_valid && in_ready;
    complete = accept && (bit_count_q == 4'd15);
    transfer = out_valid_q && out_ready;

    if (transfer) begin
      out_valid_d = 1'b0;
    end

    if (complete) begin
      out_word_d  = load_word;
      out_any_d   = load_any;
      out_valid_d = 1'b1;
      bit_count_d = 4'd0;
    end else if (accept) begin
      shift_d     = load_word[WIDTH-2:0];
      bit_count_d = bit_count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      bit_count_q <= 4'd0;
      out_word_q  <= '0;
      out_any_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_count_q <= bit_count_d;
      out_word_q  <= out_word_d;
      out_any_q   <= out_any_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_any   = out_any_q;
  assign out_valid = out_valid_q;
  assign bit_count = bit_count_q;
endmodule

// File: doc/student_deser16.md
# student_deser16

Bit-serial to 16-bit parallel deserializer with a valid/ready handshake on both sides. It expands a one-bit stream into 16-bit words, the reverse of the gate-level reductions in the project-1 library. Each completed word is presented with an `out_any` flag equal to the OR of all its bits. The block sits between a serial source and any 16-bit consumer built from the student gate library.

## Interface
- `WIDTH`, default 16, word width in bits. Only 16 is required to be supported.
- `clk`  input  1  rising-edge clock; the single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `in_bit`  input  1  serial data bit.
- `in_valid`  input  1  `in_bit` is valid this cycle.
- `in_ready`  output  1  the block accepts `in_bit` this cycle.
- `out_word`  output  16  assembled word; the first-received bit is at bit 15.
- `out_any`  output  1  OR of all bits of `out_word`.
- `out_valid`  output  1  `out_word`/`out_any` hold an unconsumed word.
- `out_ready`  input  1  the consumer takes the word this cycle.
- `bit_count`  output  4  number of bits accepted toward the current word (0..15).

## Operation
- Clock and reset:
  - One clock (`clk`).
  - Reset is synchronous and active-high (`reset`).
- A bit is accepted on a cycle where `in_valid && in_ready`. An output word transfers on a cycle where `out_valid && out_ready`.
- Shift stage:
  - On each accepted bit: `shift <= {shift[14:0], in_bit}` and `bit_count` increments.
  - When the 16th bit is accepted (`bit_count == 15`):
    - `{shift[14:0], in_bit}` loads into the output register.
    - `bit_count` wraps to 0.
    - `shift` is left unchanged; it is overwritten by the next word.
- Output register:
  - `out_word` and `out_any` load together with `out_valid <= 1`.
  - They hold stable while `out_valid && !out_ready`.
  - `out_valid` clears on a transfer unless a new word loads in the same cycle.
  - When a new word loads in the transfer cycle, `out_valid` stays 1 and the new word replaces the old one.
- `in_ready = !(bit_count == 15 && out_valid && !out_ready)`:
  - This is combinational from `out_ready`.
  - Bits 1..15 of a word are always accepted, even while the output is full. Only the completing bit stalls.
- `out_any` is computed structurally from the word being loaded. Use two `student_or8way` instances (bits 15:8 and 7:0) combined with `student_or`. Built-in reduction or `|` operators are not used.
- State summary: `bit_count` is the state variable.
  - COLLECT: `bit_count` 0..14.
  - COMPLETE: `bit_count` 15, advanced only by the accepted 16th bit.
  - The output register is an independent EMPTY/FULL flag (`out_valid`).
- Reset mid-word discards the partial word and any unconsumed output word. No partial word is ever emitted.
- `in_valid` low freezes `shift` and `bit_count`. Gaps between bits are allowed at any position.

## Timing
- Reset values:
  - `out_valid` = 0, `out_word` = 16'h0000, `out_any` = 0, `bit_count` = 0.
  - Internal `shift` = 0.
  - `in_ready` = 1 (combinational, because `out_valid` = 0).
- Latency: when the 16th bit is accepted at edge N, `out_valid` is 1 and the word is visible after edge N.
- Minimum word period is 16 cycles. Back-to-back words with `out_ready` held high sustain 1 bit/cycle with no bubbles.
- Simultaneous load and transfer at the same edge: the old word is consumed and the new word is presented. `out_valid` remains 1 and there is no gap cycle.
- `reset` has priority over every other input on the same edge.
- No combinational path from `in_bit`/`in_valid` to any output. `in_ready` depends only on registered state and `out_ready`.

## Test plan
- Reset → outputs:
  - Assert `reset` for 2 cycles with `in_valid` = 1 and `in_bit` = 1.
  - Required: `out_valid` = 0, `out_word` = 0000, `out_any` = 0, `bit_count` = 0, `in_ready` = 1 throughout.
- Single word with gaps:
  - Send 16'hA5C3 MSB-first, with `in_valid` low on every third cycle and `out_ready` = 1.
  - Required: `out_valid` rises exactly after the 16th accepted bit, with `out_word` = A5C3 and `out_any` = 1.
  - Required: `out_valid` falls one cycle later.
- All-zero word:
  - Send 16 zero bits.
  - Required: `out_word` = 0000, `out_any` = 0, `out_valid` = 1.
- Back-pressure:
  - Hold `out_ready` = 0 and send word 16'h8001 followed by 16 bits of 16'h0010.
  - Required: the first 15 bits of the second word are accepted.
  - Required: `in_ready` = 0 while `bit_count` = 15; `out_word` stays 8001.
  - Then raise `out_ready` for 1 cycle. Required: 8001 transfers, 0010 loads at the same edge, and `out_valid` stays 1.
- Streaming:
  - Send 3 words (FFFF, 0001, 1234) back-to-back with `out_ready` = 1.
  - Required: `out_valid` pulses at accepted-bit counts 16, 32 and 48 with the matching words.
  - Required: `out_any` = 1, 1, 1 and `in_ready` is never 0.
- Mid-word reset:
  - Accept 9 bits, then pulse `reset`, then send 16'h00F0.
  - Required: exactly one output, 00F0; `bit_count` = 0 immediately after the reset edge.
